// File: rtl/alu_result_writeback.sv
// Drains one captured vector ALU result to a 32-bit write port, one word per handshake.
// NARROW mode saturates each lane to OUT_W bits; WIDE mode emits each lane as low then high word.

module alu_wb_lane_sat #(
    parameter int LANE_W = 64,
    parameter int OUT_W  = 32
) (
    input  logic [LANE_W-1:0] i_lane,
    output logic [OUT_W-1:0]  o_word,
    output logic              o_sat
);
    // Signed OUT_W range limits, sign-extended to the full lane width.
    localparam logic signed [LANE_W-1:0] MAXV = {{(LANE_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [LANE_W-1:0] MINV = {{(LANE_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [LANE_W-1:0] w_val;
    assign w_val = $signed(i_lane);

    always_comb begin
        o_word = i_lane[OUT_W-1:0];
        o_sat  = 1'b0;
        if (w_val > MAXV) begin
            o_word = {1'b0, {(OUT_W-1){1'b1}}};
            o_sat  = 1'b1;
        end else if (w_val < MINV) begin
            o_word = {1'b1, {(OUT_W-1){1'b0}}};
            o_sat  = 1'b1;
        end
    end
endmodule

module alu_result_writeback #(
    parameter int LANES  = 16,
    parameter int LANE_W = 64,
    parameter int OUT_W  = 32,
    parameter int ADDR_W = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic                    i_wide,
    input  logic [ADDR_W-1:0]       i_base_addr,
    input  logic [LANES*LANE_W-1:0] i_alu_result,
    output logic                    o_wr_valid,
    input  logic                    i_wr_ready,
    output logic [ADDR_W-1:0]       o_wr_addr,
    output logic [OUT_W-1:0]        o_wr_data,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [4:0]              o_sat_count
);
    localparam int IDX_W      = $clog2(2*LANES);
    localparam int LANE_IDX_W = $clog2(LANES);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE} state_t;

    state_t                   r_state, w_next;
    logic [LANES*LANE_W-1:0]  r_result;
    logic                     r_wide;
    logic [ADDR_W-1:0]        r_base;
    logic [IDX_W-1:0]         r_idx;
    logic [4:0]               r_sat_count;

    logic [LANES-1:0][OUT_W-1:0] w_sat_word;
    logic [LANES-1:0]            w_sat_flag;
    logic [LANE_IDX_W-1:0]       w_lane;
    logic [OUT_W-1:0]            w_wide_word;
    logic                        w_write;
    logic                        w_fire;
    logic                        w_last;

    // Saturation runs off the captured copy only, so live input changes never leak in.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        alu_wb_lane_sat #(.LANE_W(LANE_W), .OUT_W(OUT_W)) u_sat (
            .i_lane (r_result[g*LANE_W +: LANE_W]),
            .o_word (w_sat_word[g]),
            .o_sat  (w_sat_flag[g])
        );
    end

    assign w_write     = (r_state == S_WRITE);
    assign w_fire      = w_write & i_wr_ready;
    assign w_lane      = r_idx[LANE_IDX_W-1:0];
    // Lane is exactly two words, so the WIDE word index maps straight onto the flat vector.
    assign w_wide_word = r_result[r_idx*OUT_W +: OUT_W];
    assign w_last      = r_wide ? (r_idx == IDX_W'(2*LANES-1)) : (r_idx == IDX_W'(LANES-1));

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_next = S_WRITE;
            S_WRITE: if (w_fire && w_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_result    <= '0;
            r_wide      <= 1'b0;
            r_base      <= '0;
            r_idx       <= '0;
            r_sat_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_result    <= i_alu_result;
                        r_wide      <= i_wide;
                        r_base      <= i_base_addr;
                        r_idx       <= '0;
                        r_sat_count <= '0;
                    end
                end
                S_WRITE: begin
                    if (w_fire) begin
                        r_idx <= r_idx + IDX_W'(1);
                        if (!r_wide && w_sat_flag[w_lane])
                            r_sat_count <= r_sat_count + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs depend only on registered state, never on i_wr_ready.
    assign o_wr_valid  = w_write;
    assign o_wr_addr   = w_write ? r_base + ADDR_W'(r_idx) : '0;
    assign o_wr_data   = w_write ? (r_wide ? w_wide_word : w_sat_word[w_lane]) : '0;
    assign o_busy      = (r_state == S_WRITE) || (r_state == S_DONE);
    assign o_done      = (r_state == S_DONE);
    assign o_sat_count = r_sat_count;
endmodule

// File: tb/tb_alu_result_writeback.sv
// Scoreboard bench for alu_result_writeback: directed vectors push expected words,
// a negedge monitor pops them on every accepted write and checks stall stability.

module tb_alu_result_writeback;
    logic          clk = 0;
    logic          rst = 1;
    logic          start = 0;
    logic          wide = 0;
    logic [7:0]    base = 0;
    logic [1023:0] vec = '0;
    logic          wr_valid;
    logic          wr_ready = 1;
    logic [7:0]    wr_addr;
    logic [31:0]   wr_data;
    logic          busy;
    logic          done;
    logic [4:0]    sat_count;

    typedef struct { logic [7:0] a; logic [31:0] d; } exp_t;
    exp_t q[$];

    int  n_checks = 0;
    int  n_fail = 0;
    int  n_acc = 0;
    bit  rnd_ready = 0;

    alu_result_writeback dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_wide(wide),
        .i_base_addr(base), .i_alu_result(vec),
        .o_wr_valid(wr_valid), .i_wr_ready(wr_ready),
        .o_wr_addr(wr_addr), .o_wr_data(wr_data),
        .o_busy(busy), .o_done(done), .o_sat_count(sat_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] a, input logic [31:0] d);
        exp_t e;
        e.a = a; e.d = d;
        q.push_back(e);
    endtask

    // Ready driver: constant 1 or pseudo-random, changed just after each rising edge.
    initial forever begin
        @(posedge clk); #1;
        wr_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: compare each accepted word, and require a stalled word to be held.
    initial begin
        bit          stall = 0;
        logic [7:0]  h_a;
        logic [31:0] h_d;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall = 0;
            end else begin
                if (stall) begin
                    chk("stall valid held", wr_valid, 1);
                    chk("stall addr held", wr_addr, h_a);
                    chk("stall data held", wr_data, h_d);
                    stall = 0;
                end
                if (wr_valid && wr_ready) begin
                    if (q.size() == 0) begin
                        chk("unexpected write", 1, 0);
                    end else begin
                        e = q.pop_front();
                        chk("wr_addr", wr_addr, e.a);
                        chk("wr_data", wr_data, e.d);
                    end
                    n_acc++;
                end else if (wr_valid) begin
                    stall = 1; h_a = wr_addr; h_d = wr_data;
                end
            end
        end
    end

    task automatic do_start(input logic w, input logic [7:0] b);
        @(negedge clk);
        wide = w; base = b; start = 1;
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic wait_done(input string nm, input int exp_cyc, input logic [4:0] exp_sat);
        int cyc = 0;
        bit got = 0;
        while (cyc < 2000 && !got) begin
            @(negedge clk);
            cyc++;
            if (done) got = 1;
        end
        chk({nm, " done seen"}, got, 1);
        if (exp_cyc > 0) chk({nm, " done latency"}, cyc, exp_cyc);
        chk({nm, " sat_count"}, sat_count, exp_sat);
        chk({nm, " busy in done"}, busy, 1);
        chk({nm, " words left"}, q.size(), 0);
        @(negedge clk);
        chk({nm, " done one cycle"}, done, 0);
        chk({nm, " idle busy"}, busy, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("reset wr_valid", wr_valid, 0);
        chk("reset wr_addr", wr_addr, 0);
        chk("reset wr_data", wr_data, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset sat_count", sat_count, 0);

        // 1: NARROW small values, back-to-back
        for (int i = 0; i < 16; i++) begin
            vec[i*64 +: 64] = 64'(i + 1);
            push(8'h10 + 8'(i), 32'(i + 1));
        end
        do_start(0, 8'h10);
        vec = '1;  // live input change must not affect the operation
        wait_done("narrow", 17, 0);

        // 2: NARROW saturation corners
        vec = '0;
        vec[0*64 +: 64] = 64'h0000_0001_0000_0000;
        vec[1*64 +: 64] = 64'hFFFF_FFFE_0000_0000;
        vec[2*64 +: 64] = 64'hFFFF_FFFF_8000_0000;
        vec[3*64 +: 64] = 64'h0000_0000_7FFF_FFFF;
        vec[4*64 +: 64] = 64'h8000_0000_0000_0000;
        vec[5*64 +: 64] = 64'h0000_0000_8000_0000;
        vec[6*64 +: 64] = 64'hFFFF_FFFF_7FFF_FFFF;
        push(8'h00, 32'h7FFF_FFFF);
        push(8'h01, 32'h8000_0000);
        push(8'h02, 32'h8000_0000);
        push(8'h03, 32'h7FFF_FFFF);
        push(8'h04, 32'h8000_0000);
        push(8'h05, 32'h7FFF_FFFF);
        push(8'h06, 32'h8000_0000);
        for (int i = 7; i < 16; i++) push(8'(i), 32'h0);
        do_start(0, 8'h00);
        wait_done("saturate", 17, 5);

        // 3: WIDE split with random stalls
        rnd_ready = 1;
        vec[0*64 +: 64] = 64'h1122_3344_5566_7788;
        push(8'h00, 32'h5566_7788);
        push(8'h01, 32'h1122_3344);
        for (int i = 1; i < 16; i++) begin
            vec[i*64 +: 64] = {32'hA000_0000 + 32'(i), 32'hB000_0000 + 32'(i)};
            push(8'(2*i), 32'hB000_0000 + 32'(i));
            push(8'(2*i + 1), 32'hA000_0000 + 32'(i));
        end
        do_start(1, 8'h00);
        wait_done("wide", 0, 0);

        // 4: NARROW address wrap with random stalls
        for (int i = 0; i < 16; i++) begin
            vec[i*64 +: 64] = 64'(32'h0C00_0000 + 32'(i));
            push(8'hF8 + 8'(i), 32'h0C00_0000 + 32'(i));
        end
        do_start(0, 8'hF8);
        wait_done("wrap", 0, 0);
        rnd_ready = 0;

        // 5: restart ignored mid-op, then reset at write 5
        begin
            int acc0;
            int t;
            for (int i = 0; i < 16; i++) begin
                vec[i*64 +: 64] = (i < 2) ? 64'h0000_0001_0000_0000 : 64'(100 + i);
                push(8'h40 + 8'(i), (i < 2) ? 32'h7FFF_FFFF : 32'(100 + i));
            end
            @(negedge clk);
            acc0 = n_acc;
            do_start(0, 8'h40);
            t = 0;
            while (n_acc < acc0 + 2 && t < 100) begin @(posedge clk); #1; t++; end
            start = 1; wide = 1; base = 8'h00; vec = ~vec;
            @(posedge clk); #1;
            start = 0;
            while (n_acc < acc0 + 5 && t < 100) begin @(posedge clk); #1; t++; end
            chk("reach write 5", n_acc - acc0, 5);
            chk("busy before rst", busy, 1);
            chk("sat before rst", sat_count, 2);
            rst = 1;
            @(posedge clk); #1;
            rst = 0;
            q.delete();
            @(negedge clk);
            chk("rst wr_valid", wr_valid, 0);
            chk("rst wr_addr", wr_addr, 0);
            chk("rst wr_data", wr_data, 0);
            chk("rst busy", busy, 0);
            chk("rst done", done, 0);
            chk("rst sat_count", sat_count, 0);
            repeat (4) begin
                @(negedge clk);
                chk("idle after rst", wr_valid, 0);
            end
        end

        // 6: normal operation after the abort
        for (int i = 0; i < 16; i++) begin
            vec[i*64 +: 64] = 64'(7 * i);
            push(8'h80 + 8'(i), 32'(7 * i));
        end
        do_start(0, 8'h80);
        wait_done("recover", 17, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
